// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: IF inst_sram request/handshake to AXI4 single-beat reads, in-order return.
// Optional: define INST_BRIDGE_RRESP_CHECK_EN to flag SLVERR/DECERR responses on inst_sram_err.
module inst_axi_rd_bridge #(
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [3:0]  ARID_VAL  = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_sram_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

   ar_state_t   state_q, state_d;
   logic [2:0]  cnt_total;
   logic [31:0] araddr_q;
   logic        room;
   logic        ar_hs;
   logic        r_hs;
   logic        unused_bits;

   assign arid    = ARID_VAL;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign araddr  = araddr_q;
   assign arvalid = (state_q == AR_BUSY);

   // Single ID and arlen=0: every beat is the last one and arrives in issue order.
   assign unused_bits = ^{rid, rlast, rresp};

   assign room  = (cnt_total < 3'(MAX_OUTST));
   assign ar_hs = arvalid & arready;

   // A beat is only taken while something is outstanding, so a stray rvalid cannot underflow the count.
   assign rready = (cnt_total != 3'd0);
   assign r_hs   = rvalid & rready;

   assign inst_sram_data_ok = r_hs;
   assign inst_sram_rdata   = r_hs ? rdata : 32'd0;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
   assign inst_sram_err = r_hs & rresp[1];
`else
   assign inst_sram_err = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_d           = state_q;
      inst_sram_addr_ok = 1'b0;
      case (state_q)
         AR_IDLE: begin
            inst_sram_addr_ok = inst_sram_req & room;
            if (inst_sram_addr_ok) state_d = AR_BUSY;
         end
         AR_BUSY: begin
            // The AR slot frees at the handshake, so a follow-on request may reuse it in the same cycle.
            inst_sram_addr_ok = inst_sram_req & room & arready;
            if (ar_hs && !inst_sram_addr_ok) state_d = AR_IDLE;
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments and clear asynchronously on resetn.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= AR_IDLE;
         araddr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (inst_sram_addr_ok) araddr_q <= inst_sram_addr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_total <= 3'd0;
      end else begin
         case ({inst_sram_addr_ok, r_hs})
            2'b10:   cnt_total <= cnt_total + 3'd1;
            2'b01:   cnt_total <= cnt_total - 3'd1;
            default: cnt_total <= cnt_total;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: single fetch, AR backpressure, outstanding limit,
// simultaneous issue/return, error response and asynchronous reset mid-flight.
module tb_inst_axi_rd_bridge;

   logic        clk;
   logic        resetn;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        inst_sram_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int n_assert = 0;
   int n_fail   = 0;
   int n_acc;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   inst_axi_rd_bridge #(.MAX_OUTST(2), .ARID_VAL(4'd0)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .inst_sram_err     (inst_sram_err),
      .arid              (arid),
      .araddr            (araddr),
      .arlen             (arlen),
      .arsize            (arsize),
      .arburst           (arburst),
      .arvalid           (arvalid),
      .arready           (arready),
      .rid               (rid),
      .rdata             (rdata),
      .rresp             (rresp),
      .rlast             (rlast),
      .rvalid            (rvalid),
      .rready            (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic single_fetch(input string pfx);
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; arready = 1'b1;
      mid();
      check({pfx, "_addr_ok_N"},  32'(inst_sram_addr_ok), 32'd1);
      check({pfx, "_arvalid_N"},  32'(arvalid), 32'd0);
      tick();
      inst_sram_req = 1'b0; inst_sram_addr = 32'h0;
      mid();
      check({pfx, "_arvalid_N1"}, 32'(arvalid), 32'd1);
      check({pfx, "_araddr_N1"},  araddr, 32'h1C00_0000);
      check({pfx, "_rready_N1"},  32'(rready), 32'd1);
      check({pfx, "_data_ok_N1"}, 32'(inst_sram_data_ok), 32'd0);
      tick();
      rvalid = 1'b1; rdata = 32'h0280_0C0C;
      mid();
      check({pfx, "_arvalid_N2"}, 32'(arvalid), 32'd0);
      check({pfx, "_data_ok_N2"}, 32'(inst_sram_data_ok), 32'd1);
      check({pfx, "_rdata_N2"},   inst_sram_rdata, 32'h0280_0C0C);
      check({pfx, "_err_N2"},     32'(inst_sram_err), 32'd0);
      tick();
      rvalid = 1'b0; rdata = 32'h0;
      mid();
      check({pfx, "_rready_N3"},  32'(rready), 32'd0);
      check({pfx, "_data_ok_N3"}, 32'(inst_sram_data_ok), 32'd0);
      tick();
   endtask

   initial begin
      resetn = 1'b0; inst_sram_req = 1'b0; inst_sram_addr = 32'h0;
      arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

      // Reset state and constant AR fields
      #3;
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_araddr",  araddr, 32'h0);
      check("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
      check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
      check("rst_rdata",   inst_sram_rdata, 32'h0);
      check("rst_err",     32'(inst_sram_err), 32'd0);
      check("rst_rready",  32'(rready), 32'd0);
      check("const_arid",  32'(arid), 32'h0);
      check("const_arlen", 32'(arlen), 32'h0);
      check("const_arsize", 32'(arsize), 32'h2);
      check("const_arburst", 32'(arburst), 32'h1);
      tick();
      resetn = 1'b1;
      tick();

      // Single fetch
      single_fetch("sf");

      // AR backpressure while IF keeps changing its address
      arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010;
      mid();
      check("bp_addr_ok_first", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         inst_sram_addr = 32'h1C00_0020 + 32'(4 * i);
         mid();
         check("bp_arvalid_held", 32'(arvalid), 32'd1);
         check("bp_araddr_held",  araddr, 32'h1C00_0010);
         check("bp_no_addr_ok",   32'(inst_sram_addr_ok), 32'd0);
         tick();
      end
      arready = 1'b1; inst_sram_addr = 32'h1C00_0040;
      mid();
      check("bp_addr_ok_at_hs", 32'(inst_sram_addr_ok), 32'd1);
      check("bp_araddr_at_hs",  araddr, 32'h1C00_0010);
      tick();
      inst_sram_req = 1'b0;
      mid();
      check("bp_arvalid_2nd", 32'(arvalid), 32'd1);
      check("bp_araddr_2nd",  araddr, 32'h1C00_0040);
      tick();
      rvalid = 1'b1; rdata = 32'hA1A1_0001;
      mid();
      check("bp_data_ok_1", 32'(inst_sram_data_ok), 32'd1);
      check("bp_rdata_1",   inst_sram_rdata, 32'hA1A1_0001);
      tick();
      rdata = 32'hA2A2_0002;
      mid();
      check("bp_data_ok_2", 32'(inst_sram_data_ok), 32'd1);
      check("bp_rdata_2",   inst_sram_rdata, 32'hA2A2_0002);
      tick();
      rvalid = 1'b0; rdata = 32'h0;
      mid();
      check("bp_rready_idle", 32'(rready), 32'd0);
      tick();

      // Outstanding limit: three requests, R held off for 10 cycles
      n_acc = 0;
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; arready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         mid();
         if (inst_sram_addr_ok) begin
            n_acc++;
            if (n_acc == 1) check("ol_araddr_src0", inst_sram_addr, 32'h1C00_0000);
         end
         tick();
         if (n_acc == 1) inst_sram_addr = 32'h1C00_0004;
         if (n_acc == 2) inst_sram_addr = 32'h1C00_0008;
      end
      check("ol_accept_count", 32'(n_acc), 32'd2);
      check("ol_rready_full",  32'(rready), 32'd1);
      check("ol_araddr_last",  araddr, 32'h1C00_0004);
      rvalid = 1'b1; rdata = 32'hD000_0000;
      mid();
      check("ol_data_ok_0",     32'(inst_sram_data_ok), 32'd1);
      check("ol_rdata_0",       inst_sram_rdata, 32'hD000_0000);
      check("ol_third_blocked", 32'(inst_sram_addr_ok), 32'd0);
      tick();
      rvalid = 1'b0;
      mid();
      check("ol_third_accepted", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0004;
      mid();
      check("ol_data_ok_1", 32'(inst_sram_data_ok), 32'd1);
      check("ol_rdata_1",   inst_sram_rdata, 32'hD000_0004);
      check("ol_araddr_3rd", araddr, 32'h1C00_0008);
      check("ol_arvalid_3rd", 32'(arvalid), 32'd1);
      tick();

      // Error response on the third beat
      rdata = 32'hD000_0008; rresp = 2'b10;
      mid();
      check("er_data_ok", 32'(inst_sram_data_ok), 32'd1);
      check("er_err",     32'(inst_sram_err), 32'(EXP_ERR));
      tick();
      rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
      mid();
      check("er_rready_idle", 32'(rready), 32'd0);
      check("er_err_idle",    32'(inst_sram_err), 32'd0);
      tick();

      // Simultaneous issue and return with one outstanding
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100; arready = 1'b1;
      mid();
      check("si_addr_ok_a", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0;
      tick();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0104; rvalid = 1'b1; rdata = 32'hE000_0000;
      mid();
      check("si_addr_ok_b", 32'(inst_sram_addr_ok), 32'd1);
      check("si_data_ok",   32'(inst_sram_data_ok), 32'd1);
      check("si_rdata",     inst_sram_rdata, 32'hE000_0000);
      tick();
      inst_sram_req = 1'b0; rvalid = 1'b0;
      mid();
      check("si_arvalid_next", 32'(arvalid), 32'd1);
      check("si_araddr_next",  araddr, 32'h1C00_0104);
      check("si_cnt_one",      32'(rready), 32'd1);
      check("si_no_data_ok",   32'(inst_sram_data_ok), 32'd0);
      tick();
      rvalid = 1'b1; rdata = 32'hE000_0004;
      mid();
      check("si_rdata_b", inst_sram_rdata, 32'hE000_0004);
      tick();
      rvalid = 1'b0;
      mid();
      check("si_rready_idle", 32'(rready), 32'd0);
      tick();

      // Asynchronous reset with two outstanding and AR pending
      arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200;
      tick();
      arready = 1'b1; inst_sram_addr = 32'h1C00_0204;
      mid();
      check("ar_addr_ok_2nd", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'hF000_0000;
      mid();
      check("ar_pre_arvalid", 32'(arvalid), 32'd1);
      check("ar_pre_data_ok", 32'(inst_sram_data_ok), 32'd1);
      #1 resetn = 1'b0;
      #1;
      check("ar_arvalid_async", 32'(arvalid), 32'd0);
      check("ar_rready_async",  32'(rready), 32'd0);
      check("ar_data_ok_async", 32'(inst_sram_data_ok), 32'd0);
      check("ar_araddr_async",  araddr, 32'h0);
      rvalid = 1'b0; rdata = 32'h0;
      tick();
      #2 resetn = 1'b1;
      tick();
      single_fetch("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
